// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//   Parametrised VGA raster timing generator. A horizontal counter (hc) and a
//   vertical counter (vc) walk the full raster, including porches and sync.
//   Every output is a registered decode of the same hc/vc pair, so the
//   position, sync, blank, data-enable and strobe outputs always describe
//   the same pixel, one pix_en later than the counters.
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-high reset
//   pix_en      pixel clock enable; nothing advances while it is low
//   resync      restart the raster at (0,0); only acts together with pix_en
//   pix_x/pix_y position of the pixel currently presented on the outputs
//   hsync/vsync sync pulses, active level set by HSYNC_POL/VSYNC_POL
//   hblank      pix_x is outside the visible area
//   vblank      pix_y is outside the visible area
//   de          visible pixel (neither blank)
//   line_start  one-enable strobe at pix_x == 0
//   frame_start one-enable strobe at pix_x == 0 and pix_y == 0
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CNT_W     = 11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pix_en,
  input  logic             resync,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             hsync,
  output logic             vsync,
  output logic             hblank,
  output logic             vblank,
  output logic             de,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Parameter sanity: counters must hold TOTAL-1, and a zero-width porch or
  // sync would collapse region boundaries the decode relies on.
  if (H_TOTAL > (2 ** CNT_W) || V_TOTAL > (2 ** CNT_W)) begin : g_bad_width
    $error("vga_timing_gen: CNT_W too small for H_TOTAL/V_TOTAL");
  end
  if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_timing
    $error("vga_timing_gen: porch and sync widths must be non-zero");
  end

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0] hc_q, hc_d, vc_q, vc_d;
  logic [CNT_W-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic             hsync_q, hsync_d, vsync_q, vsync_d;
  logic             hblank_q, hblank_d, vblank_q, vblank_d;
  logic             de_q, de_d, line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;

  logic hs_act, vs_act, hb_cur, vb_cur;

  // Decode of the current (pre-increment) counter position.
  assign hs_act = (hc_q >= HS_START) && (hc_q < HS_END);
  assign vs_act = (vc_q >= VS_START) && (vc_q < VS_END);
  assign hb_cur = (hc_q >= H_VIS);
  assign vb_cur = (vc_q >= V_VIS);

  always_comb begin
    // NOTE: every *_d gets a hold default first so no path leaves a value
    // unassigned; otherwise synthesis would infer a latch.
    hc_d          = hc_q;
    vc_d          = vc_q;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    hblank_d      = hblank_q;
    vblank_d      = vblank_q;
    de_d          = de_q;
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;

    if (pix_en) begin
      // Counter advance; resync forces the next position to (0,0).
      if (resync) begin
        hc_d = '0;
        vc_d = '0;
      end else if (hc_q == H_LAST) begin
        hc_d = '0;
        vc_d = (vc_q == V_LAST) ? '0 : vc_q + ONE;
      end else begin
        hc_d = hc_q + ONE;
      end

      // Output stage always describes the current position, even on resync.
      pix_x_d       = hc_q;
      pix_y_d       = vc_q;
      hsync_d       = hs_act ? HSYNC_POL : ~HSYNC_POL;
      vsync_d       = vs_act ? VSYNC_POL : ~VSYNC_POL;
      hblank_d      = hb_cur;
      vblank_d      = vb_cur;
      de_d          = !hb_cur && !vb_cur;
      line_start_d  = (hc_q == '0);
      frame_start_d = (hc_q == '0) && (vc_q == '0);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before this edge, independent of order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hc_q          <= '0;
      vc_q          <= '0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      hblank_q      <= 1'b1;
      vblank_q      <= 1'b1;
      de_q          <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign hblank      = hblank_q;
  assign vblank      = vblank_q;
  assign de          = de_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA raster timing generator. It replaces the standalone horizontal counter with one block that has joint horizontal and vertical counters, configurable porch, sync and total timings, and selectable sync polarity. It also provides a pixel clock-enable, a synchronous frame re-sync input, and registered, mutually aligned position, sync, blank and data-enable outputs with line and frame strobes. It sits between the clock/reset infrastructure and the pixel pipeline that renders the matrix results.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HSYNC_POL, 0, active level of hsync (0 = active-low)
VSYNC_POL, 0, active level of vsync
CNT_W, 11, width of the position counters; must hold max(H_TOTAL, V_TOTAL) - 1

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
pix_en  input  1  pixel clock enable; all state advances only when high
resync  input  1  synchronous request to restart the raster at (0,0)
pix_x  output  CNT_W  horizontal position of the current output pixel
pix_y  output  CNT_W  vertical position of the current output pixel
hsync  output  1  horizontal sync, polarity per HSYNC_POL
vsync  output  1  vertical sync, polarity per VSYNC_POL
hblank  output  1  high when pix_x >= H_ACTIVE
vblank  output  1  high when pix_y >= V_ACTIVE
de  output  1  data enable = !hblank && !vblank
line_start  output  1  one-pix_en pulse when pix_x == 0
frame_start  output  1  one-pix_en pulse when pix_x == 0 and pix_y == 0

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP; V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP.
- Internal counters hc and vc are both CNT_W wide.
- On reset, hc = vc = 0 and the outputs are:
  - pix_x = pix_y = 0
  - hsync = !HSYNC_POL, vsync = !VSYNC_POL
  - hblank = vblank = 1
  - de = line_start = frame_start = 0
- When pix_en is low, every register holds, including pulse outputs. Pulses therefore last exactly one pix_en-qualified cycle.
- Counter advance on each pix_en:
  - hc = (hc == H_TOTAL-1) ? 0 : hc+1.
  - When hc == H_TOTAL-1: vc = (vc == V_TOTAL-1) ? 0 : vc+1. Otherwise vc holds.
  - hc never reaches H_TOTAL; vc never reaches V_TOTAL.
- Output stage (registered, one pix_en of latency): on each pix_en, the output registers load a decode of the pre-increment hc/vc.
  - pix_x <= hc, pix_y <= vc.
  - hsync active iff H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC.
  - vsync active iff V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC.
  - hblank, vblank, de, line_start, frame_start decode from the same hc/vc.
  - All outputs are mutually cycle-aligned and describe the same pixel.
- resync:
  - Acts only together with pix_en.
  - resync && pix_en: hc <= 0 and vc <= 0, so the counter position following the current one becomes (0,0). The output stage still loads the decode of the current hc/vc on that cycle.
  - On the next pix_en the outputs show (0,0) with frame_start = 1.
  - resync without pix_en is ignored (it is not latched).
  - resync while hc/vc are already at (H_TOTAL-1, V_TOTAL-1) gives the same result as a natural wrap.
- Reset may assert mid-frame; it takes effect immediately regardless of pix_en or resync.
- The first pix_en after reset release outputs (0,0) with de = 1, line_start = 1, frame_start = 1.
- No arithmetic overflow is permitted. An elaboration check must fail if H_TOTAL or V_TOTAL exceeds 2^CNT_W, or if any porch or sync parameter is 0.

Test Plan:
- Reset release, pix_en held high, defaults -> first outputs pix_x = 0, pix_y = 0, de = 1, frame_start = 1; pix_x reaches 799, then returns to 0 with pix_y = 1; line_start repeats every 800 cycles.
- Horizontal timing -> hsync low exactly for pix_x 656..751 (96 cycles); hblank high for pix_x 640..799; de low whenever pix_y >= 480.
- Vertical timing -> vsync low only for pix_y 490..491; frame_start period = 420000 pix_en cycles; pix_y wraps 524 -> 0.
- pix_en toggling 1-of-4 -> position and all outputs advance once per enabled cycle; pulses held across disabled cycles; frame period = 1680000 clk.
- resync && pix_en at pix_x = 300, pix_y = 200 -> outputs show (300,200) on that enable, then (0,0) with frame_start = 1 on the next; resync with pix_en = 0 -> no effect.
- reset asserted at pix_x = 700, pix_y = 490 -> hsync and vsync go inactive and pix_x = pix_y = 0 immediately (asynchronously); HSYNC_POL = 1 variant -> hsync high for pix_x 656..751 and low at reset.
